// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: owns the state register, fetches round keys and applies AddRoundKey.
// Optional AES_ROUND_CTRL_ABORT_EN adds a synchronous i_abort input.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic         i_abort,
`endif
  input  logic         i_start_valid,
  output logic         o_start_ready,
  input  logic         i_mode,
  input  logic [127:0] i_data,
  output logic         o_rk_req,
  output logic [3:0]   o_rk_idx,
  input  logic         i_rk_valid,
  input  logic [127:0] i_rk,
  output logic [127:0] o_rnd_data,
  output logic         o_rnd_mode,
  output logic         o_rnd_last,
  input  logic [127:0] i_rnd_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data,
  output logic         o_busy,
  output logic [3:0]   o_round
);

  localparam int unsigned RW   = 4;
  localparam logic [RW-1:0] NR_W = RW'(NR);

  typedef enum logic [1:0] {IDLE, ARK0, ROUND, DONE} fsm_e;

  fsm_e           fsm_q;
  logic [127:0]   blk_q;
  logic [RW-1:0]  round_q;
  logic           mode_q;
  logic           abort_c;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_c = i_abort && (fsm_q != IDLE);
`else
  assign abort_c = 1'b0;
`endif

  // Sequencer: abort wins over every other transition
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fsm_q   <= IDLE;
      blk_q   <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
    end else if (abort_c) begin
      fsm_q   <= IDLE;
      round_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (i_start_valid) begin
            blk_q   <= i_data;
            mode_q  <= i_mode;
            round_q <= '0;
            fsm_q   <= ARK0;
          end
        end
        ARK0: begin
          if (i_rk_valid) begin
            blk_q   <= blk_q ^ i_rk;
            round_q <= RW'(1);
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          if (i_rk_valid) begin
            blk_q <= i_rnd_data ^ i_rk;
            if (round_q == NR_W) begin
              fsm_q <= DONE;
            end else begin
              round_q <= round_q + RW'(1);
            end
          end
        end
        DONE: begin
          if (i_ready) begin
            fsm_q   <= IDLE;
            round_q <= '0;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Key index runs backwards for the equivalent inverse cipher
  always_comb begin
    o_rk_idx = '0;
    case (fsm_q)
      ARK0:    o_rk_idx = mode_q ? NR_W : '0;
      ROUND:   o_rk_idx = mode_q ? (NR_W - round_q) : round_q;
      default: o_rk_idx = '0;
    endcase
  end

  assign o_start_ready = (fsm_q == IDLE);
  assign o_rk_req      = (fsm_q == ARK0) || (fsm_q == ROUND);
  assign o_rnd_last    = (fsm_q == ROUND) && (round_q == NR_W);
  assign o_rnd_data    = blk_q;
  assign o_rnd_mode    = mode_q;
  assign o_valid       = (fsm_q == DONE);
  assign o_data        = blk_q;
  assign o_busy        = (fsm_q != IDLE);
  assign o_round       = round_q;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 round sequencer. It owns the 128-bit state register and steps one external combinational round datapath through the initial AddRoundKey and NR rounds. The round datapath is SubBytes/ShiftRows/MixColumns, or the inverse set for decryption. The block requests round keys by index from the key-expansion block, applies AddRoundKey itself, and sits between the UART framing logic (block in/out) and the round datapath.

Parameters:
NR, 10, number of rounds; the round counter is 4 bits wide and legal values are 1..15.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_start_valid  input  1  input block valid
o_start_ready  output  1  block accepted when high together with i_start_valid
i_mode  input  1  0 = encrypt, 1 = decrypt; sampled on acceptance
i_data  input  128  input block
o_rk_req  output  1  round-key request
o_rk_idx  output  4  requested round-key index
i_rk_valid  input  1  i_rk holds the key for o_rk_idx
i_rk  input  128  round key
o_rnd_data  output  128  state presented to round datapath, equal to the state register
o_rnd_mode  output  1  latched mode
o_rnd_last  output  1  final round, so the datapath skips (Inv)MixColumns
i_rnd_data  input  128  combinational round datapath result
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_data  output  128  result, equal to the state register
o_busy  output  1  high in any state except IDLE
o_round  output  4  current round counter

Behaviour:
- Reset (asynchronous, i_rst high): FSM goes to IDLE. The state register, round counter and mode clear to 0. o_valid=0, o_rk_req=0, o_busy=0, o_start_ready=1 (combinational from IDLE), o_rnd_last=0.
- Reset mid-operation: the block is abandoned with no output, and the FSM is back in IDLE on the first clock after release.
- FSM states: IDLE, ARK0, ROUND, DONE.
- IDLE:
  - o_start_ready=1.
  - On i_start_valid: state<=i_data, mode<=i_mode, round<=0, go to ARK0.
- ARK0:
  - o_rk_req=1.
  - o_rk_idx = 0 for encrypt, NR for decrypt.
  - Stall while i_rk_valid=0.
  - On i_rk_valid: state<=state^i_rk, round<=1, go to ROUND.
- ROUND:
  - o_rk_req=1.
  - o_rk_idx = round for encrypt, NR-round for decrypt.
  - o_rnd_last = (round==NR).
  - Stall while i_rk_valid=0; the state register is unchanged during a stall.
  - On i_rk_valid: state<=i_rnd_data^i_rk.
  - If round==NR, go to DONE. Otherwise round<=round+1.
- Decrypt uses the equivalent inverse cipher. The key source supplies InvMixColumns-transformed keys for indices 1..NR-1; the controller treats both modes identically apart from index order.
- DONE:
  - o_valid=1 and o_data stable until i_ready.
  - On i_ready, go to IDLE.
- New-block timing: o_start_ready is low in DONE, so a new block is accepted no earlier than the cycle after the output handshake.
- Latency with i_rk_valid tied high: accept at edge 0, ARK0 takes 1 cycle, NR ROUND cycles follow, and o_valid rises NR+1 cycles after acceptance (11 for NR=10).
- Ignored inputs: i_rk_valid is ignored when o_rk_req=0. i_start_valid is ignored outside IDLE.
- o_rk_idx is 0 and o_rnd_last is 0 outside ARK0/ROUND.
- o_round reflects the counter: 0 in IDLE/ARK0, NR in DONE.

Optional Feature:
AES_ROUND_CTRL_ABORT_EN.
- When defined: adds input port i_abort (1 bit, synchronous).
  - i_abort high in ARK0, ROUND or DONE forces the next state to IDLE.
  - It clears round to 0 and drops o_valid and o_rk_req on the next edge. The state register is left unchanged.
  - i_abort has priority over every other transition, including an output handshake and an i_rk_valid in the same cycle.
  - i_abort is ignored in IDLE.
- When undefined: the port is absent and the FSM is as above.

Test Plan:
- Encrypt FIPS-197 C.1 (pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f), reference datapath and key schedule, i_rk_valid=1 -> o_data=69c4e0d86a7b0430d8cdb78070b4c55a, o_valid exactly 11 cycles after acceptance, o_rk_idx sequence 0..10.
- Decrypt ct 69c4e0d86a7b0430d8cdb78070b4c55a with the same key -> o_data=00112233445566778899aabbccddeeff, o_rk_idx sequence 10..0, o_rnd_last high only when o_round=10.
- Key stalls: i_rk_valid low for 3 cycles at rounds 0, 5 and 10 -> same ciphertext, o_valid at cycle 20, o_rnd_data constant during each stall.
- Backpressure: i_ready low for 5 cycles in DONE with i_start_valid held high -> o_data stable, o_start_ready=0 until the cycle after the i_ready handshake, then the second block is accepted.
- i_rst pulsed during round 4 -> all outputs return to reset values immediately; the next block encrypts correctly with 11-cycle latency.
- (ABORT_EN) i_abort in round 6 together with i_rk_valid -> IDLE next cycle, o_valid never asserts, next block is correct.
